// File: rtl/core_defines.sv
// rtl/core_defines.sv - shared RV32I constants, opcode encodings and immediate generator
//
// Purpose : common definitions for the decode stage and its register file.
// Contents: XLEN, NREG, REG_W, OP_* opcode localparams, imm_gen() helper.
package core_defines;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int REG_W = $clog2(NREG);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Sign-extended immediate selected by the opcode's encoding format.
  // OP/unknown opcodes carry no immediate and return zero.
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ins);
    logic [XLEN-1:0] v;
    v = '0;
    case (ins[6:0])
      OP_JALR, OP_LOAD, OP_IMM:
        v = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:
        v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:
        v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        v = {ins[31:12], 12'b0};
      OP_JAL:
        v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/decode/execute/writeback bundle for the decode stage
//
// Purpose : groups every non-clock/reset signal of the decode stage.
// Modports: slave  - the decode stage (consumes fd_*/wb_*/ex_stall/flush,
//                    drives d_ready and the de_* pipeline register)
//           master - the surrounding pipeline / environment.
interface decode_stage_if;
  import core_defines::*;

  logic [XLEN-1:0]  fd_pc;
  logic [31:0]      fd_instr;
  logic             ex_stall;
  logic             flush;
  logic             wb_en;
  logic [REG_W-1:0] wb_rd;
  logic [XLEN-1:0]  wb_data;

  logic             d_ready;
  logic             de_valid;
  logic [XLEN-1:0]  de_pc;
  logic [XLEN-1:0]  de_rs1_val;
  logic [XLEN-1:0]  de_rs2_val;
  logic [XLEN-1:0]  de_imm;
  logic [REG_W-1:0] de_rs1;
  logic [REG_W-1:0] de_rs2;
  logic [REG_W-1:0] de_rd;
  logic [6:0]       de_opcode;
  logic [2:0]       de_funct3;
  logic             de_funct7b5;
  logic             de_we;
  logic             de_mem_rd;
  logic             de_mem_wr;
  logic             de_branch;
  logic             de_jal;
  logic             de_jalr;
  logic             de_illegal;

  modport slave (
    input  fd_pc, fd_instr, ex_stall, flush, wb_en, wb_rd, wb_data,
    output d_ready, de_valid, de_pc, de_rs1_val, de_rs2_val, de_imm,
           de_rs1, de_rs2, de_rd, de_opcode, de_funct3, de_funct7b5,
           de_we, de_mem_rd, de_mem_wr, de_branch, de_jal, de_jalr, de_illegal
  );

  modport master (
    output fd_pc, fd_instr, ex_stall, flush, wb_en, wb_rd, wb_data,
    input  d_ready, de_valid, de_pc, de_rs1_val, de_rs2_val, de_imm,
           de_rs1, de_rs2, de_rd, de_opcode, de_funct3, de_funct7b5,
           de_we, de_mem_rd, de_mem_wr, de_branch, de_jal, de_jalr, de_illegal
  );

endinterface

// File: rtl/decode_stage_regfile.sv
// rtl/decode_stage_regfile.sv - 32x32 register file, 2 async reads, 1 sync write
//
// Purpose : architectural registers with x0 hardwired to zero and a
//           write-through path so a same-cycle writeback is visible on reads.
// Ports   : i_clk, i_rst (sync, active-high clear)
//           i_raddr1/o_rdata1, i_raddr2/o_rdata2 - combinational read ports
//           i_wen, i_waddr, i_wdata              - synchronous write port
module decode_stage_regfile
  import core_defines::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [REG_W-1:0] i_raddr1,
  input  logic [REG_W-1:0] i_raddr2,
  output logic [XLEN-1:0]  o_rdata1,
  output logic [XLEN-1:0]  o_rdata2,
  input  logic             i_wen,
  input  logic [REG_W-1:0] i_waddr,
  input  logic [XLEN-1:0]  i_wdata
);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_wr_live;

  // x0 is never written, so a write addressed to it is dropped everywhere.
  assign w_wr_live = i_wen && (i_waddr != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wr_live) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if (i_raddr1 != '0) o_rdata1 = (w_wr_live && i_waddr == i_raddr1) ? i_wdata : r_mem[i_raddr1];
    if (i_raddr2 != '0) o_rdata2 = (w_wr_live && i_waddr == i_raddr2) ? i_wdata : r_mem[i_raddr2];
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with load-use and flush handling
//
// Purpose : decodes fd_instr, reads operands, computes the immediate and
//           registers everything into the de_* pipeline register (1 cycle).
// Ports   : clock, reset (sync, active-high)
//           bus (decode_stage_if.slave): fd_pc/fd_instr in, ex_stall, flush,
//           wb_en/wb_rd/wb_data writeback, d_ready out, de_* register outputs.
module decode_stage
  import core_defines::*;
(
  input  logic          clock,
  input  logic          reset,
  decode_stage_if.slave bus
);

  // Field extraction
  logic [6:0]       w_opcode;
  logic [REG_W-1:0] w_rd, w_rs1, w_rs2;
  logic             w_bubble;
  assign w_opcode = bus.fd_instr[6:0];
  assign w_rd     = bus.fd_instr[11:7];
  assign w_rs1    = bus.fd_instr[19:15];
  assign w_rs2    = bus.fd_instr[24:20];
  assign w_bubble = (bus.fd_instr == 32'h0);

  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_imm, w_op;
  assign w_lui   = (w_opcode == OP_LUI);
  assign w_auipc = (w_opcode == OP_AUIPC);
  assign w_jal   = (w_opcode == OP_JAL);
  assign w_jalr  = (w_opcode == OP_JALR);
  assign w_br    = (w_opcode == OP_BRANCH);
  assign w_ld    = (w_opcode == OP_LOAD);
  assign w_st    = (w_opcode == OP_STORE);
  assign w_imm   = (w_opcode == OP_IMM);
  assign w_op    = (w_opcode == OP_OP);

  // A bubble has opcode 0, so it is never "legal" and every control bit it
  // would load is already 0; it is excluded from illegal explicitly.
  logic w_legal, w_illegal, w_rs1_used, w_rs2_used, w_we;
  assign w_legal    = w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_imm | w_op;
  assign w_illegal  = !w_bubble && !w_legal;
  assign w_rs1_used = w_jalr | w_br | w_ld | w_st | w_imm | w_op;
  assign w_rs2_used = w_br | w_st | w_op;
  assign w_we       = (w_rd != '0) && (w_lui | w_auipc | w_jal | w_jalr | w_ld | w_imm | w_op);

  logic [XLEN-1:0] w_rs1_val, w_rs2_val;

  decode_stage_regfile u_regfile (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_rs1_val),
    .o_rdata2 (w_rs2_val),
    .i_wen    (bus.wb_en),
    .i_waddr  (bus.wb_rd),
    .i_wdata  (bus.wb_data)
  );

  // de_* pipeline register
  logic             r_de_valid, r_squash_pend;
  logic [XLEN-1:0]  r_de_pc, r_de_rs1_val, r_de_rs2_val, r_de_imm;
  logic [REG_W-1:0] r_de_rs1, r_de_rs2, r_de_rd;
  logic [6:0]       r_de_opcode;
  logic [2:0]       r_de_funct3;
  logic             r_de_funct7b5, r_de_we, r_de_mem_rd, r_de_mem_wr;
  logic             r_de_branch, r_de_jal, r_de_jalr, r_de_illegal;

  // The load in de_* produces its result too late for an immediate consumer.
  logic w_load_use;
  assign w_load_use = r_de_valid && r_de_mem_rd && (r_de_rd != '0) && !w_bubble &&
                      ((w_rs1_used && w_rs1 == r_de_rd) || (w_rs2_used && w_rs2 == r_de_rd));

  // Flush must always be accepted so fetch can redirect even under a stall.
  assign bus.d_ready = bus.flush || (!bus.ex_stall && !w_load_use);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_de_valid    <= 1'b0;
      r_squash_pend <= 1'b0;
      r_de_pc       <= '0;
      r_de_rs1_val  <= '0;
      r_de_rs2_val  <= '0;
      r_de_imm      <= '0;
      r_de_rs1      <= '0;
      r_de_rs2      <= '0;
      r_de_rd       <= '0;
      r_de_opcode   <= '0;
      r_de_funct3   <= '0;
      r_de_funct7b5 <= 1'b0;
      r_de_we       <= 1'b0;
      r_de_mem_rd   <= 1'b0;
      r_de_mem_wr   <= 1'b0;
      r_de_branch   <= 1'b0;
      r_de_jal      <= 1'b0;
      r_de_jalr     <= 1'b0;
      r_de_illegal  <= 1'b0;
    end else if (!bus.flush && bus.ex_stall) begin
      // hold everything
    end else if (bus.flush || w_load_use || r_squash_pend) begin
      // Inject a bubble: data fields stay stale, side-effecting controls drop.
      r_de_valid    <= 1'b0;
      r_de_we       <= 1'b0;
      r_de_mem_rd   <= 1'b0;
      r_de_mem_wr   <= 1'b0;
      r_de_branch   <= 1'b0;
      r_de_jal      <= 1'b0;
      r_de_jalr     <= 1'b0;
      r_de_illegal  <= 1'b0;
      // Flush arms the one-word squash; load_use leaves it untouched so a
      // pending squash survives until a normal advance consumes it.
      if (bus.flush)          r_squash_pend <= 1'b1;
      else if (!w_load_use)   r_squash_pend <= 1'b0;
    end else begin
      r_de_valid    <= !w_bubble;
      r_de_pc       <= bus.fd_pc;
      r_de_rs1_val  <= w_rs1_val;
      r_de_rs2_val  <= w_rs2_val;
      r_de_imm      <= imm_gen(bus.fd_instr);
      r_de_rs1      <= w_rs1;
      r_de_rs2      <= w_rs2;
      r_de_rd       <= w_rd;
      r_de_opcode   <= w_opcode;
      r_de_funct3   <= bus.fd_instr[14:12];
      r_de_funct7b5 <= bus.fd_instr[30];
      r_de_we       <= w_legal && w_we;
      r_de_mem_rd   <= w_ld;
      r_de_mem_wr   <= w_st;
      r_de_branch   <= w_br;
      r_de_jal      <= w_jal;
      r_de_jalr     <= w_jalr;
      r_de_illegal  <= w_illegal;
    end
  end

  assign bus.de_valid    = r_de_valid;
  assign bus.de_pc       = r_de_pc;
  assign bus.de_rs1_val  = r_de_rs1_val;
  assign bus.de_rs2_val  = r_de_rs2_val;
  assign bus.de_imm      = r_de_imm;
  assign bus.de_rs1      = r_de_rs1;
  assign bus.de_rs2      = r_de_rs2;
  assign bus.de_rd       = r_de_rd;
  assign bus.de_opcode   = r_de_opcode;
  assign bus.de_funct3   = r_de_funct3;
  assign bus.de_funct7b5 = r_de_funct7b5;
  assign bus.de_we       = r_de_we;
  assign bus.de_mem_rd   = r_de_mem_rd;
  assign bus.de_mem_wr   = r_de_mem_wr;
  assign bus.de_branch   = r_de_branch;
  assign bus.de_jal      = r_de_jal;
  assign bus.de_jalr     = r_de_jalr;
  assign bus.de_illegal  = r_de_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  decode_stage_if bus ();

  decode_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
    bus.fd_pc    = pc;
    bus.fd_instr = ins;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset        = 1'b1;
    bus.fd_pc    = '0;
    bus.fd_instr = '0;
    bus.ex_stall = 1'b0;
    bus.flush    = 1'b0;
    bus.wb_en    = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;

    // Reset held for two cycles
    tick();
    tick();
    chk("rst_valid",   {31'b0, bus.de_valid}, 32'h0);
    chk("rst_pc",      bus.de_pc, 32'h0);
    chk("rst_imm",     bus.de_imm, 32'h0);
    chk("rst_we",      {31'b0, bus.de_we}, 32'h0);
    chk("rst_opcode",  {25'b0, bus.de_opcode}, 32'h0);
    chk("rst_illegal", {31'b0, bus.de_illegal}, 32'h0);
    chk("rst_d_ready", {31'b0, bus.d_ready}, 32'h1);

    // addi x1,x0,5
    reset = 1'b0;
    drive(32'h10, 32'h00500093);
    tick();
    chk("addi_valid", {31'b0, bus.de_valid}, 32'h1);
    chk("addi_pc",    bus.de_pc, 32'h10);
    chk("addi_rd",    {27'b0, bus.de_rd}, 32'h1);
    chk("addi_imm",   bus.de_imm, 32'h5);
    chk("addi_we",    {31'b0, bus.de_we}, 32'h1);
    chk("addi_rs1v",  bus.de_rs1_val, 32'h0);

    // add x3,x2,x2 with same-cycle writeback of x2
    bus.wb_en   = 1'b1;
    bus.wb_rd   = 5'd2;
    bus.wb_data = 32'hDEADBEEF;
    drive(32'h14, 32'h002101B3);
    tick();
    bus.wb_en = 1'b0;
    chk("byp_rs1v", bus.de_rs1_val, 32'hDEADBEEF);
    chk("byp_rs2v", bus.de_rs2_val, 32'hDEADBEEF);
    chk("byp_rd",   {27'b0, bus.de_rd}, 32'h3);

    // lw x5,0(x1) then add x6,x5,x0 -> one load-use bubble
    drive(32'h18, 32'h0000A283);
    tick();
    chk("lw_memrd",  {31'b0, bus.de_mem_rd}, 32'h1);
    chk("lw_funct3", {29'b0, bus.de_funct3}, 32'h2);
    chk("lw_we",     {31'b0, bus.de_we}, 32'h1);
    drive(32'h1C, 32'h00028333);
    #1;
    chk("lu_d_ready", {31'b0, bus.d_ready}, 32'h0);
    tick();
    chk("lu_bubble", {31'b0, bus.de_valid}, 32'h0);
    chk("lu_memrd",  {31'b0, bus.de_mem_rd}, 32'h0);
    chk("lu_ready2", {31'b0, bus.d_ready}, 32'h1);
    tick();
    chk("lu_add_valid", {31'b0, bus.de_valid}, 32'h1);
    chk("lu_add_rs1",   {27'b0, bus.de_rs1}, 32'h5);
    chk("lu_add_rd",    {27'b0, bus.de_rd}, 32'h6);

    // flush with ex_stall: bubble, squash next word, third word issues
    bus.flush    = 1'b1;
    bus.ex_stall = 1'b1;
    drive(32'h20, 32'h00100393);
    #1;
    chk("fl_d_ready", {31'b0, bus.d_ready}, 32'h1);
    tick();
    chk("fl_bubble", {31'b0, bus.de_valid}, 32'h0);
    bus.flush    = 1'b0;
    bus.ex_stall = 1'b0;
    drive(32'h24, 32'h00200413);
    tick();
    chk("fl_squash", {31'b0, bus.de_valid}, 32'h0);
    chk("fl_sq_we",  {31'b0, bus.de_we}, 32'h0);
    drive(32'h40, 32'h00300493);
    tick();
    chk("fl_third_valid", {31'b0, bus.de_valid}, 32'h1);
    chk("fl_third_rd",    {27'b0, bus.de_rd}, 32'h9);
    chk("fl_third_pc",    bus.de_pc, 32'h40);
    chk("fl_third_imm",   bus.de_imm, 32'h3);

    // ex_stall holds de_*
    bus.ex_stall = 1'b1;
    drive(32'h44, 32'h00500513);
    #1;
    chk("st_d_ready", {31'b0, bus.d_ready}, 32'h0);
    tick();
    chk("st_hold_rd", {27'b0, bus.de_rd}, 32'h9);
    chk("st_hold_pc", bus.de_pc, 32'h40);
    bus.ex_stall = 1'b0;

    // illegal opcode
    drive(32'h48, 32'hFFFFFFFF);
    tick();
    chk("ill_illegal", {31'b0, bus.de_illegal}, 32'h1);
    chk("ill_valid",   {31'b0, bus.de_valid}, 32'h1);
    chk("ill_we",      {31'b0, bus.de_we}, 32'h0);
    chk("ill_memrd",   {31'b0, bus.de_mem_rd}, 32'h0);
    chk("ill_jal",     {31'b0, bus.de_jal}, 32'h0);

    // sw x2,4(x0): S immediate, rs2 from register file
    drive(32'h4C, 32'h00202223);
    tick();
    chk("sw_imm",   bus.de_imm, 32'h4);
    chk("sw_memwr", {31'b0, bus.de_mem_wr}, 32'h1);
    chk("sw_we",    {31'b0, bus.de_we}, 32'h0);
    chk("sw_rs2v",  bus.de_rs2_val, 32'hDEADBEEF);

    // beq x0,x0,-4: negative B immediate
    drive(32'h50, 32'hFE000EE3);
    tick();
    chk("beq_imm",    bus.de_imm, 32'hFFFFFFFC);
    chk("beq_branch", {31'b0, bus.de_branch}, 32'h1);
    chk("beq_we",     {31'b0, bus.de_we}, 32'h0);

    // lui x10,0x12345
    drive(32'h54, 32'h12345537);
    tick();
    chk("lui_imm", bus.de_imm, 32'h12345000);
    chk("lui_we",  {31'b0, bus.de_we}, 32'h1);

    // jal x0,8: rd=0 never writes
    drive(32'h58, 32'h0080006F);
    tick();
    chk("jal_imm", bus.de_imm, 32'h8);
    chk("jal_jal", {31'b0, bus.de_jal}, 32'h1);
    chk("jal_we",  {31'b0, bus.de_we}, 32'h0);

    // write to x0 (bubble in decode), then read x0 with write still asserted
    bus.wb_en   = 1'b1;
    bus.wb_rd   = 5'd0;
    bus.wb_data = 32'h1234;
    drive(32'h5C, 32'h0);
    tick();
    chk("bub_valid", {31'b0, bus.de_valid}, 32'h0);
    chk("bub_jal",   {31'b0, bus.de_jal}, 32'h0);
    drive(32'h60, 32'h00000093);
    tick();
    bus.wb_en = 1'b0;
    chk("x0_rs1v", bus.de_rs1_val, 32'h0);
    chk("x0_valid", {31'b0, bus.de_valid}, 32'h1);

    // reset in the middle of a stall
    bus.ex_stall = 1'b1;
    reset = 1'b1;
    tick();
    chk("rst_stall_valid", {31'b0, bus.de_valid}, 32'h0);
    chk("rst_stall_pc",    bus.de_pc, 32'h0);
    reset = 1'b0;
    bus.ex_stall = 1'b0;
    drive(32'h70, 32'h00028333);
    tick();
    chk("post_rst_rs1v", bus.de_rs1_val, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
